alu_multicycle: RTL and testbench
=================================

# alu_multicycle

Parametrised, registered ALU for the datapath. It keeps the existing control encoding zero-extended to 4 bits and adds XOR, NOR, shifts, signed and unsigned compare, and an iterative shift-add multiply. A Start/Busy/Done handshake lets the control FSM stall while a multiply is in progress. Outputs are registered and held until the next operation completes.

## Interface
- WIDTH, 32: operand and result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH): shift-amount width; derived, do not override.
- clk  in  1: clock, rising edge.
- rst  in  1: synchronous, active-high reset.
- Start  in  1: request; sampled only while Busy=0.
- ALUCtl  in  4: operation code, sampled at accept.
- OP1  in  WIDTH: operand A, sampled at accept.
- OP2  in  WIDTH: operand B, sampled at accept.
- Res  out  WIDTH: registered result.
- ZF  out  1: registered; 1 when Res==0.
- OF  out  1: registered signed overflow (ADD/SUB only, else 0).
- Busy  out  1: multi-cycle operation in progress.
- Done  out  1: one-cycle pulse; Res, ZF and OF updated this cycle.

## Operation
- ALUCtl encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 NOP (Res=0).
  - 0111 SLT: signed compare, Res=1 if OP1<OP2 else 0.
  - 0100 XOR, 0101 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA: shift OP1 by OP2[SHW-1:0]; upper OP2 bits are ignored.
  - 1011 SLTU: unsigned compare.
  - 1100 MUL: low WIDTH bits of OP1*OP2; signedness is irrelevant for the low half.
  - All other codes: Res=0, single-cycle.
- ADD/SUB wrap modulo 2^WIDTH.
  - OF for ADD is set when the operands have equal signs and the result sign differs.
  - OF for SUB is set when the operands have different signs and the result sign differs from OP1.
- FSM states:
  - IDLE, on accept with single-cycle op: compute, write Res/ZF/OF, pulse Done, stay in IDLE.
  - IDLE, on accept with MUL: latch multiplicand, multiplier and ALUCtl; clear accumulator; set counter=0; go to MUL.
  - MUL: each cycle, if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left 1 and multiplier right 1; counter+1.
  - MUL exit: when counter reaches WIDTH-1 on an iteration, write Res=accumulator (including that iteration), ZF from it, OF=0, pulse Done, go to IDLE.
- Accept means Start=1 and Busy=0 at a rising edge.
- Start while Busy=1 is ignored; it is not queued.
- Operand changes after accept have no effect.
- Res, ZF and OF change only on Done (or reset).

## Timing
- Reset values: Res=0, ZF=1, OF=0, Busy=0, Done=0; FSM in IDLE, counter=0.
- Single-cycle ops: accept at edge E0, so Res/ZF/OF/Done are valid in the cycle after E0 (latency 1). Busy stays 0.
- MUL latency:
  - Busy=1 in the cycles after E0 … E(WIDTH-1).
  - Iterations occur at edges E1 … E(WIDTH).
  - Done=1 and Busy=0 in the cycle after E(WIDTH); latency is WIDTH+1 cycles.
- Done is exactly one cycle wide and never coincides with Busy=1.
- Back-to-back: Start held high gives one accept per Done. A new accept is legal in the same cycle Done=1, because Busy=0 then.
- rst asserted during MUL aborts it:
  - No Done pulse.
  - Res returns to 0 next cycle.
  - Start sampled in the reset cycle is ignored.
- rst and Start both high: reset wins.

## Test plan
- Reset, then idle 5 cycles -> Res=0, ZF=1, OF=0, Busy=0, Done=0 throughout.
- ADD 0x7FFFFFFF+1 -> one cycle later Res=0x80000000, OF=1, ZF=0, Done pulse; SUB 5-5 -> Res=0, ZF=1, OF=0.
- SLT 0xFFFFFFFF vs 1 -> Res=1; SLTU on the same operands -> Res=0; SRA 0x80000000 by OP2=0x24 (shift 4) -> Res=0xF8000000; SRL on the same operands -> 0x08000000.
- MUL 0x0001_2345 × 0x0000_0100 with Start held high:
  - Busy high for 32 cycles, then Done with Res=0x0123_4500.
  - Start pulses mid-MUL are ignored.
  - The next op is accepted in the Done cycle.
- MUL 0xFFFFFFFF × 0xFFFFFFFF -> Res=0x00000001; illegal ALUCtl 1111 -> Res=0, ZF=1, single-cycle.
- rst raised at iteration 10 of a MUL -> no Done, Busy=0 and Res=0 the next cycle, then a fresh ADD 2+3 -> Res=5.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU. Single-cycle logic/arith/shift/compare ops
// finish one cycle after accept. MUL is an iterative shift-add that takes
// WIDTH iterations. Start/Busy/Done handshake; results held until next Done.
//
// state | meaning
// IDLE  | waiting for Start; single-cycle ops complete from here
// MUL   | shift-add multiply iterating, Busy=1
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [3:0]       ALUCtl,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic [WIDTH-1:0] Res,
    output logic             ZF,
    output logic             OF,
    output logic             Busy,
    output logic             Done
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             sc_of;
    logic [WIDTH-1:0] acc_next;

    assign sum      = OP1 + OP2;
    assign diff     = OP1 - OP2;
    assign shamt    = OP2[SHW-1:0];
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // single-cycle result and overflow for the operation presented at accept
    always_comb begin
        sc_res = '0;
        sc_of  = 1'b0;
        case (ALUCtl)
            OP_AND:  sc_res = OP1 & OP2;
            OP_OR:   sc_res = OP1 | OP2;
            OP_ADD: begin
                sc_res = sum;
                sc_of  = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (sum[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_of  = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (diff[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_NOP:  sc_res = '0;
            OP_XOR:  sc_res = OP1 ^ OP2;
            OP_NOR:  sc_res = ~(OP1 | OP2);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (OP1 < OP2)};
            OP_SLL:  sc_res = OP1 << shamt;
            OP_SRL:  sc_res = OP1 >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(OP1) >>> shamt);
            default: sc_res = '0;
        endcase
    end

    // control FSM, multiply datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Res    <= '0;
            ZF     <= 1'b1;
            OF     <= 1'b0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (ALUCtl == OP_MUL) begin
                            mcand  <= OP1;
                            mplier <= OP2;
                            acc    <= '0;
                            cnt    <= '0;
                            Busy   <= 1'b1;
                            state  <= MUL;
                        end else begin
                            Res  <= sc_res;
                            ZF   <= (sc_res == '0);
                            OF   <= sc_of;
                            Done <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + SHW'(1);
                    if (cnt == LAST_ITER) begin
                        Res   <= acc_next;
                        ZF    <= (acc_next == '0);
                        OF    <= 1'b0;
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vectors, Start-held MUL,
// reset abort mid-MUL and random ops, all through an expectation queue.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [3:0]  ALUCtl;
    logic [31:0] OP1;
    logic [31:0] OP2;
    logic [31:0] Res;
    logic        ZF;
    logic        OF;
    logic        Busy;
    logic        Done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        of;
        int          lat;
    } exp_t;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zf;
        logic        of;
    } vec_t;

    exp_t exp_q[$];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .Start(Start), .ALUCtl(ALUCtl),
        .OP1(OP1), .OP2(OP2), .Res(Res), .ZF(ZF), .OF(OF),
        .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;

    // independent reference model using wide signed arithmetic
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.res = 32'h0;
        e.of  = 1'b0;
        e.lat = 1;
        case (c)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2: begin
                wide  = sa + sb;
                e.res = wide[31:0];
                e.of  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd6: begin
                wide  = sa - sb;
                e.res = wide[31:0];
                e.of  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
            end
            4'd7:  e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  e.res = a ^ b;
            4'd5:  e.res = ~(a | b);
            4'd8:  e.res = a << b[4:0];
            4'd9:  e.res = a >> b[4:0];
            4'd10: begin
                wide  = sa >>> b[4:0];
                e.res = wide[31:0];
            end
            4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin
                wide  = longint'({32'h0, a}) * longint'({32'h0, b});
                e.res = wide[31:0];
                e.lat = 33;
            end
            default: e.res = 32'h0;
        endcase
        e.zf = (e.res == 32'h0);
        return e;
    endfunction

    // drive one request, let it be accepted at the next edge
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold);
        ALUCtl = c;
        OP1    = a;
        OP2    = b;
        Start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) Start = 1'b0;
    endtask

    // count negedges after accept until Done, bounded
    task automatic wait_done(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (Done) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        Start  = 1'b0;
        ALUCtl = 4'h0;
        OP1    = 32'h0;
        OP2    = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({Res, ZF, OF, Busy, Done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got Res=%h ZF=%b OF=%b Busy=%b Done=%b, want Res=0 ZF=1 OF=0 Busy=0 Done=0",
                         i, Res, ZF, OF, Busy, Done);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        vec_t vecs[$];
        exp_t e;
        exp_t g;
        int   lat;
        bit   ok;
        vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{4'b0110, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0});
        vecs.push_back('{4'b1011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{4'b1010, 32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{4'b1001, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1'b0});
        vecs.push_back('{4'b1000, 32'h1,        32'h3F,       32'h80000000, 1'b0, 1'b0});
        vecs.push_back('{4'b0100, 32'hF0F0,     32'hFF00,     32'h0FF0,     1'b0, 1'b0});
        vecs.push_back('{4'b0101, 32'h0,        32'h0,        32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{4'b0000, 32'hFF00,     32'h0F0F,     32'h0F00,     1'b0, 1'b0});
        vecs.push_back('{4'b0001, 32'h1200,     32'h0034,     32'h1234,     1'b0, 1'b0});
        vecs.push_back('{4'b0011, 32'h5,        32'h6,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{4'b0110, 32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{4'b0010, 32'h3,        32'h4,        32'h7,        1'b0, 1'b0});
        vecs.push_back('{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b0});
        vecs.push_back('{4'b1111, 32'h1234,     32'h5678,     32'h0,        1'b1, 1'b0});
        foreach (vecs[k]) begin
            e.res = vecs[k].res;
            e.zf  = vecs[k].zf;
            e.of  = vecs[k].of;
            e.lat = (vecs[k].ctl == 4'b1100) ? 33 : 1;
            exp_q.push_back(e);
            issue(vecs[k].ctl, vecs[k].a, vecs[k].b, 1'b0);
            wait_done(40, lat, ok);
            g = exp_q.pop_front();
            n_checks++;
            if (!ok || lat != g.lat) begin
                n_fail++;
                $display("FAIL directed_latency[%0d] ctl=%b: got %0d cycles (done=%0b), want %0d", k, vecs[k].ctl, lat, ok, g.lat);
            end
            n_checks++;
            if ({Res, ZF, OF, Busy} !== {g.res, g.zf, g.of, 1'b0}) begin
                n_fail++;
                $display("FAIL directed_result[%0d] ctl=%b: got Res=%h ZF=%b OF=%b Busy=%b, want Res=%h ZF=%b OF=%b Busy=0",
                         k, vecs[k].ctl, Res, ZF, OF, Busy, g.res, g.zf, g.of);
            end
            @(negedge clk);
            n_checks++;
            if (Done !== 1'b0 || Res !== g.res) begin
                n_fail++;
                $display("FAIL directed_hold[%0d]: got Done=%b Res=%h, want Done=0 Res=%h", k, Done, Res, g.res);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        exp_t g;
        int   busy_cnt;
        int   lat;
        bit   ok;
        busy_cnt = 0;
        ok       = 1'b0;
        lat      = 0;
        exp_q.push_back(model(4'b1100, 32'h0001_2345, 32'h0000_0100));
        exp_q.push_back(model(4'b0010, 32'd10, 32'd20));
        issue(4'b1100, 32'h0001_2345, 32'h0000_0100, 1'b1);
        // next op presented while busy with Start still high: must wait for Done
        ALUCtl = 4'b0010;
        OP1    = 32'd10;
        OP2    = 32'd20;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (Done) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
            if (Busy) busy_cnt++;
            if (i == 10) Start = 1'b0;
            if (i == 11) Start = 1'b1;
        end
        g = exp_q.pop_front();
        n_checks++;
        if (!ok || busy_cnt != 32 || lat != 33) begin
            n_fail++;
            $display("FAIL mul_busy: got busy_cycles=%0d done_at=%0d, want busy_cycles=32 done_at=33", busy_cnt, lat);
        end
        n_checks++;
        if ({Res, ZF, OF, Busy} !== {g.res, g.zf, g.of, 1'b0}) begin
            n_fail++;
            $display("FAIL mul_result: got Res=%h ZF=%b OF=%b Busy=%b, want Res=%h ZF=%b OF=%b Busy=0",
                     Res, ZF, OF, Busy, g.res, g.zf, g.of);
        end
        n_checks++;
        if (g.res !== 32'h0123_4500) begin
            n_fail++;
            $display("FAIL mul_model: got %h, want 01234500", g.res);
        end
        @(posedge clk);
        #1 Start = 1'b0;
        wait_done(1, lat, ok);
        g = exp_q.pop_front();
        n_checks++;
        if (!ok || Res !== g.res || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got done=%0b Res=%h Busy=%b, want done=1 Res=%h Busy=0", ok, Res, Busy, g.res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        exp_t g;
        int   lat;
        bit   ok;
        n_checks++;
        if (Res === 32'h0) begin
            n_fail++;
            $display("FAIL abort_precondition: got Res=%h, want nonzero", Res);
        end
        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst    = 1'b1;
        Start  = 1'b1;
        ALUCtl = 4'b0010;
        OP1    = 32'd7;
        OP2    = 32'd7;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        Start = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({Res, ZF, OF, Busy, Done} !== {32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state: got Res=%h ZF=%b OF=%b Busy=%b Done=%b, want Res=0 ZF=1 OF=0 Busy=0 Done=0",
                     Res, ZF, OF, Busy, Done);
        end
        wait_done(35, lat, ok);
        n_checks++;
        if (ok) begin
            n_fail++;
            $display("FAIL abort_no_done: got Done after %0d cycles, want none", lat);
        end
        @(posedge clk);
        #1;
        exp_q.push_back(model(4'b0010, 32'd2, 32'd3));
        issue(4'b0010, 32'd2, 32'd3, 1'b0);
        wait_done(2, lat, ok);
        g = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != 1 || Res !== g.res || Res !== 32'd5) begin
            n_fail++;
            $display("FAIL abort_then_add: got done=%0b lat=%0d Res=%h, want done=1 lat=1 Res=00000005", ok, lat, Res);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        exp_t        g;
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        bit          ok;
        for (int k = 0; k < 30; k++) begin
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if (k % 5 == 0) b = a;
            exp_q.push_back(model(c, a, b));
            issue(c, a, b, 1'b0);
            wait_done(40, lat, ok);
            g = exp_q.pop_front();
            n_checks++;
            if (!ok || lat != g.lat || {Res, ZF, OF} !== {g.res, g.zf, g.of}) begin
                n_fail++;
                $display("FAIL random[%0d] ctl=%b a=%h b=%h: got Res=%h ZF=%b OF=%b lat=%0d, want Res=%h ZF=%b OF=%b lat=%0d",
                         k, c, a, b, Res, ZF, OF, lat, g.res, g.zf, g.of, g.lat);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
